clk_div_sched: RTL
==================

Name: clk_div_sched

Overview:
- Runtime-programmable clock-divide scheduler.
- Generates a divided clock (clk_out) and a matching single-cycle enable (clk_en) from clk_in, for even and odd ratios.
- Accepts new divide ratios over a valid/ready handshake and applies them only at a period boundary, so no runt or stretched pulses occur.
- Sits between the register/config logic and the divided-clock consumers; replaces fixed-ratio dividers where the ratio must change at run time.

Parameters:
- WIDTH, 8, bit width of divide ratio and internal counter.
- DEFAULT_DIV, 4, ratio active after reset; must be >= 2 and < 2^WIDTH.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- cfg_valid  input  1  new ratio request.
- cfg_div  input  WIDTH  requested ratio M; 0 = stop, 1 = illegal, >= 2 = divide by M.
- cfg_ready  output  1  request can be accepted this cycle.
- cfg_err  output  1  one-cycle pulse: accepted request had cfg_div == 1, so it was discarded.
- clk_out  output  1  divided clock, registered.
- clk_en  output  1  one-cycle pulse on each clk_out rising period start, registered.
- cur_div  output  WIDTH  ratio currently in effect; 0 when stopped.
- busy  output  1  a ratio change is pending.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = RUN, cur_div = DEFAULT_DIV, counter = DEFAULT_DIV-1.
  - clk_out = 0, clk_en = 0, cfg_err = 0, busy = 0, pend_div cleared.
  - A reset mid-operation discards any pending change immediately.
- States:
  - RUN: dividing by cur_div.
  - PEND: dividing by cur_div, new ratio held in pend_div.
  - STOP: clk_out = 0, clk_en = 0, counter held at 0.
- Counter, in RUN/PEND:
  - Counts 0..cur_div-1, then wraps.
  - The edge where the counter wraps to 0 is the boundary; clk_out -> 1 and clk_en -> 1 on that edge.
  - clk_out -> 0 on the edge where the counter becomes cur_div>>1.
  - clk_en -> 0 on every other edge.
  - Duty: high for floor(M/2) cycles, low for ceil(M/2) cycles (M=5: 2 high, 3 low; M=4: 2/2).
  - First boundary is the first rising edge after reset release.
- Handshake:
  - cfg_ready = 1 in RUN and STOP, 0 in PEND.
  - A transfer occurs on an edge with cfg_valid & cfg_ready.
  - cfg_div == 1: discarded; cfg_err = 1 for exactly the next cycle; state unchanged.
  - cfg_div == cur_div: no-op; state unchanged.
  - Otherwise in RUN: pend_div <- cfg_div, state -> PEND, busy = 1.
  - In STOP with cfg_div >= 2: cur_div <- cfg_div, counter <- cfg_div-1, state -> RUN. The next edge is a boundary.
  - In STOP with cfg_div == 0: no-op.
- PEND resolution, at the next boundary edge:
  - pend_div >= 2: cur_div <- pend_div, counter <- 0, clk_out -> 1, clk_en -> 1, state -> RUN, busy -> 0. The new period starts at that edge.
  - pend_div == 0: cur_div <- 0, counter <- 0, clk_out -> 0, clk_en -> 0, state -> STOP, busy -> 0.
- Simultaneous events:
  - Transfer accepted on a RUN boundary edge: that boundary uses the old ratio, and the change applies at the following boundary. This means one full old period always completes after acceptance.
- Output changes:
  - cur_div changes only on a boundary edge or a STOP->RUN transfer.
  - clk_out never toggles with a high or low phase shorter than min(floor(old/2), floor(new/2)) cycles.
- Width:
  - Counter and comparisons are WIDTH bits unsigned.
  - Maximum ratio is 2^WIDTH-1; no overflow because the counter never exceeds cur_div-1.

Test Plan:
- Reset release, DEFAULT_DIV=4 -> clk_out pattern 1,1,0,0 repeating from the first edge; clk_en pulses every 4 cycles; cur_div=4; cfg_ready=1.
- Odd ratio: cfg_div=5 accepted mid-period -> busy=1, cfg_ready=0 until the next boundary; thereafter clk_out 1,1,0,0,0 and cur_div=5; the prior div-4 period completes intact.
- Request cfg_div=3 held valid on the exact boundary edge -> boundary still div-4; div-3 (1,0,0) starts at the following boundary.
- cfg_div=1 -> cfg_err pulse of 1 cycle; cur_div, clk_out sequence and state unchanged.
- cfg_div=0 -> after the current period, clk_out=0, clk_en=0, cur_div=0. Then cfg_div=2 -> next edge is a boundary, then clk_out 1,0 repeating.
- Assert rst low while in PEND (cur_div=4, pend 7) -> outputs return to reset values immediately; after release, div-4 resumes and pend 7 is never applied.

Source files
------------

// File: rtl/clk_div_sched.sv
// Runtime-programmable clock divider: produces clk_out/clk_en from clk_in and
// swaps in a new divide ratio only at a period boundary.
module clk_div_sched #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             clk_en,
  output logic [WIDTH-1:0] cur_div,
  output logic             busy
);

  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] CNT_RST  = WIDTH'(DEFAULT_DIV - 1);
  localparam logic [WIDTH-1:0] DIV_ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] div_nxt;
  logic [WIDTH-1:0] pend_div, pend_nxt;
  logic             err_nxt, out_nxt, en_nxt;
  logic             xfer, boundary;

  // Next-state, counter and output decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_nxt   = cur_div;
    pend_nxt  = pend_div;
    err_nxt   = 1'b0;
    xfer      = cfg_valid & cfg_ready;
    boundary  = (state != STOP) && (cnt == cur_div - DIV_ONE);

    if (state != STOP) begin
      cnt_nxt = boundary ? '0 : cnt + DIV_ONE;
    end

    case (state)
      RUN: begin
        if (xfer) begin
          if (cfg_div == DIV_ONE) begin
            err_nxt = 1'b1;
          end else if (cfg_div != cur_div) begin
            pend_nxt  = cfg_div;
            state_nxt = PEND;
          end
        end
      end
      PEND: begin
        if (boundary) begin
          div_nxt   = pend_div;
          state_nxt = (pend_div == '0) ? STOP : RUN;
        end
      end
      STOP: begin
        cnt_nxt = '0;
        if (xfer) begin
          if (cfg_div == DIV_ONE) begin
            err_nxt = 1'b1;
          end else if (cfg_div != '0) begin
            div_nxt   = cfg_div;
            cnt_nxt   = cfg_div - DIV_ONE;
            state_nxt = RUN;
          end
        end
      end
      default: begin
        state_nxt = RUN;
        div_nxt   = DIV_RST;
        cnt_nxt   = CNT_RST;
      end
    endcase

    // High for the first floor(M/2) counts of each period
    out_nxt = (state_nxt != STOP) && (cnt_nxt < (div_nxt >> 1));
    en_nxt  = boundary && (state_nxt != STOP);
  end

  // State and registered outputs
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      cnt       <= CNT_RST;
      cur_div   <= DIV_RST;
      pend_div  <= '0;
      clk_out   <= 1'b0;
      clk_en    <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cur_div   <= div_nxt;
      pend_div  <= pend_nxt;
      clk_out   <= out_nxt;
      clk_en    <= en_nxt;
      cfg_err   <= err_nxt;
      cfg_ready <= (state_nxt != PEND);
      busy      <= (state_nxt == PEND);
    end
  end

endmodule
